alu_issue_queue: RTL and testbench

//  Upstream issue stage for the 4-bit combinational ALU. Buffers operation requests
//  (opcode, operands, carry-in) in a small FIFO and presents one request at a time
//  to the ALU inputs. Captures the ALU result and carry-out in an output register,

---
 rtl/alu_issue_queue.sv | 176 +++++++++++++++++
 tb/tb_alu_issue_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Issue stage for the 4-bit combinational ALU: buffers requests in a small FIFO,
// presents the head to the ALU and holds the result in a valid/ready output register.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_opcode,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_cin,
    input  logic       in_cin_sel,
    output logic [3:0] aluin_a,
    output logic [3:0] aluin_b,
    output logic [3:0] OPCODE,
    output logic       Cin,
    input  logic [3:0] alu_out,
    input  logic       Cout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_cout,
    output logic       res_illegal
);

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       cin_sel;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          slot_free;
    logic          capture;
    logic          res_valid_d;
    logic          carry_q;
    state_t        state_q;
    state_t        state_d;

    function automatic logic is_illegal(input logic [3:0] op);
        case (op)
            4'b1000, 4'b1001, 4'b1010,
            4'b0000, 4'b0001, 4'b0010,
            4'b0100, 4'b0101: is_illegal = 1'b0;
            default:          is_illegal = 1'b1;
        endcase
    endfunction

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign slot_free = !res_valid || res_ready;
    assign capture   = !empty && slot_free;
    assign head      = mem[rd_ptr];

    // The ALU sees the FIFO head directly; with nothing queued all its inputs rest at zero.
    always_comb begin
        aluin_a = '0;
        aluin_b = '0;
        OPCODE  = '0;
        Cin     = 1'b0;
        if (!empty) begin
            aluin_a = head.a;
            aluin_b = head.b;
            OPCODE  = head.opcode;
            Cin     = head.cin_sel ? carry_q : head.cin;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{opcode: in_opcode, a: in_a, b: in_b,
                             cin: in_cin, cin_sel: in_cin_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (capture) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
        end
    end

    always_comb begin
        count_d = count;
        case ({push, capture})
            2'b10:   count_d = count + (AW+1)'(1);
            2'b01:   count_d = count - (AW+1)'(1);
            default: count_d = count;
        endcase
    end

    // carry_q follows every capture so chained ops see the Cout of the op issued just before.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_cout    <= 1'b0;
            res_illegal <= 1'b0;
            carry_q     <= 1'b0;
        end else if (capture) begin
            res_valid   <= 1'b1;
            res_data    <= alu_out;
            res_cout    <= Cout;
            res_illegal <= is_illegal(head.opcode);
            carry_q     <= Cout;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign res_valid_d = capture || (res_valid && !res_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status tracker only; the datapath is governed by the FIFO count and slot handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (count_d == '0 && !res_valid_d) begin
                    state_d = IDLE;
                end else if (res_valid && !res_ready) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (res_ready) begin
                    state_d = (count_d == '0 && !res_valid_d) ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural 4-bit ALU closing the loop.
module tb_alu_issue_queue;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_cin;
    logic       in_cin_sel;
    logic [3:0] aluin_a;
    logic [3:0] aluin_b;
    logic [3:0] alu_opcode;
    logic       alu_cin;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_cout;
    logic       res_illegal;

    int assertCount = 0;
    int failCount   = 0;

    alu_issue_queue #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .in_cin_sel (in_cin_sel),
        .aluin_a    (aluin_a),
        .aluin_b    (aluin_b),
        .OPCODE     (alu_opcode),
        .Cin        (alu_cin),
        .alu_out    (alu_out),
        .Cout       (alu_cout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_cout   (res_cout),
        .res_illegal(res_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; unknown opcodes return 0/0.
    always_comb begin
        logic [4:0] sum;
        sum      = '0;
        alu_out  = '0;
        alu_cout = 1'b0;
        case (alu_opcode)
            4'b1000: begin sum = {1'b0, aluin_a} + {1'b0, aluin_b}; alu_out = sum[3:0]; alu_cout = sum[4]; end
            4'b1001: begin sum = {1'b0, aluin_a} + {1'b0, aluin_b} + {4'b0, alu_cin}; alu_out = sum[3:0]; alu_cout = sum[4]; end
            4'b1010: begin sum = {1'b0, aluin_a} + {1'b0, ~aluin_b} + 5'd1; alu_out = sum[3:0]; alu_cout = sum[4]; end
            4'b0000: alu_out = aluin_a & aluin_b;
            4'b0001: alu_out = aluin_a | aluin_b;
            4'b0010: alu_out = aluin_a ^ aluin_b;
            4'b0100: alu_out = ~aluin_a;
            4'b0101: alu_out = aluin_a;
            default: begin alu_out = '0; alu_cout = 1'b0; end
        endcase
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic ci, input logic sel,
                                 input logic rdy);
        in_valid   = v;
        in_opcode  = op;
        in_a       = a;
        in_b       = b;
        in_cin     = ci;
        in_cin_sel = sel;
        res_ready  = rdy;
        @(negedge clk);
    endtask

    task automatic sendIdle(input logic rdy);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        int expSum;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_a       = '0;
        in_b       = '0;
        in_cin     = 1'b0;
        in_cin_sel = 1'b0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("rst_res_valid", 8'(res_valid), 8'h0);
        checkOutput("rst_in_ready", 8'(in_ready), 8'h1);
        checkOutput("rst_res_data", 8'(res_data), 8'h0);
        checkOutput("rst_res_cout", 8'(res_cout), 8'h0);
        checkOutput("rst_res_illegal", 8'(res_illegal), 8'h0);
        checkOutput("rst_aluin_a", 8'(aluin_a), 8'h0);
        checkOutput("rst_cin", 8'(alu_cin), 8'h0);
        rst_n = 1'b1;

        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 4'h8, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0);
        checkOutput("ms_head_a", 8'(aluin_a), 8'hF);
        applyStimulus(1'b1, 4'h8, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
        checkOutput("ms_res_data", 8'(res_data), 8'h0);
        checkOutput("ms_res_cout", 8'(res_cout), 8'h1);
        applyStimulus(1'b1, 4'h8, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h8, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0);
        checkOutput("ms_head_before_rst", 8'(aluin_a), 8'h1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ms_rst_res_valid", 8'(res_valid), 8'h0);
        checkOutput("ms_rst_in_ready", 8'(in_ready), 8'h1);
        checkOutput("ms_rst_opcode", 8'(alu_opcode), 8'h0);
        checkOutput("ms_rst_res_cout", 8'(res_cout), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'h9, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("ms_carry_cleared", 8'(alu_cin), 8'h0);
        sendIdle(1'b1);
        checkOutput("ms_chain_valid", 8'(res_valid), 8'h1);
        checkOutput("ms_chain_data", 8'(res_data), 8'h0);
        sendIdle(1'b1);
        checkOutput("ms_drained", 8'(res_valid), 8'h0);

        $display("[TB] single op");
        applyStimulus(1'b1, 4'h8, 4'h9, 4'h8, 1'b0, 1'b0, 1'b1);
        checkOutput("single_aluin_a", 8'(aluin_a), 8'h9);
        checkOutput("single_aluin_b", 8'(aluin_b), 8'h8);
        checkOutput("single_opcode", 8'(alu_opcode), 8'h8);
        checkOutput("single_not_yet", 8'(res_valid), 8'h0);
        sendIdle(1'b1);
        checkOutput("single_valid", 8'(res_valid), 8'h1);
        checkOutput("single_data", 8'(res_data), 8'h1);
        checkOutput("single_cout", 8'(res_cout), 8'h1);
        checkOutput("single_illegal", 8'(res_illegal), 8'h0);
        checkOutput("single_idle_alu", 8'(aluin_a), 8'h0);
        sendIdle(1'b1);
        checkOutput("single_drain", 8'(res_valid), 8'h0);

        $display("[TB] carry chain");
        applyStimulus(1'b1, 4'h8, 4'hF, 4'h1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h9, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("chain1_data", 8'(res_data), 8'h0);
        checkOutput("chain1_cout", 8'(res_cout), 8'h1);
        checkOutput("chain2_cin", 8'(alu_cin), 8'h1);
        sendIdle(1'b1);
        checkOutput("chain2_data", 8'(res_data), 8'h1);
        checkOutput("chain2_cout", 8'(res_cout), 8'h0);
        sendIdle(1'b1);

        $display("[TB] chain after logic op");
        applyStimulus(1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'h0, 4'hF, 4'h3, 1'b0, 1'b0, 1'b1);
        checkOutput("logic_add_data", 8'(res_data), 8'hE);
        checkOutput("logic_add_cout", 8'(res_cout), 8'h1);
        applyStimulus(1'b1, 4'h9, 4'h1, 4'h1, 1'b0, 1'b1, 1'b1);
        checkOutput("logic_and_data", 8'(res_data), 8'h3);
        checkOutput("logic_and_cout", 8'(res_cout), 8'h0);
        checkOutput("logic_chain_cin", 8'(alu_cin), 8'h0);
        sendIdle(1'b1);
        checkOutput("logic_chain_data", 8'(res_data), 8'h2);
        sendIdle(1'b1);

        $display("[TB] backpressure");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 4'h8, 4'(i), 4'h1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("bp_full", 8'(in_ready), 8'h0);
        checkOutput("bp_valid", 8'(res_valid), 8'h1);
        checkOutput("bp_held", 8'(res_data), 8'h2);
        applyStimulus(1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_stable", 8'(res_data), 8'h2);
        checkOutput("bp_still_full", 8'(in_ready), 8'h0);
        for (int k = 0; k < 4; k++) begin
            sendIdle(1'b1);
            checkOutput("bp_release_valid", 8'(res_valid), 8'h1);
            checkOutput("bp_release_data", 8'(res_data), 8'(k + 3));
        end
        checkOutput("bp_ready_again", 8'(in_ready), 8'h1);
        sendIdle(1'b1);
        checkOutput("bp_no_extra", 8'(res_valid), 8'h0);

        $display("[TB] illegal opcode");
        applyStimulus(1'b1, 4'h3, 4'h5, 4'h5, 1'b0, 1'b0, 1'b1);
        sendIdle(1'b1);
        checkOutput("illegal_valid", 8'(res_valid), 8'h1);
        checkOutput("illegal_data", 8'(res_data), 8'h0);
        checkOutput("illegal_cout", 8'(res_cout), 8'h0);
        checkOutput("illegal_flag", 8'(res_illegal), 8'h1);
        sendIdle(1'b1);
        checkOutput("illegal_drain", 8'(res_valid), 8'h0);

        $display("[TB] stream");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'h8, 4'(i), 4'h3, 1'b0, 1'b0, 1'b1);
            if (i > 0) begin
                expSum = (i - 1) + 3;
                checkOutput("stream_valid", 8'(res_valid), 8'h1);
                checkOutput("stream_data", 8'(res_data), 8'(expSum % 16));
                checkOutput("stream_cout", 8'(res_cout), 8'(expSum > 15));
            end
        end
        sendIdle(1'b1);
        checkOutput("stream_last_data", 8'(res_data), 8'h2);
        checkOutput("stream_last_cout", 8'(res_cout), 8'h1);
        sendIdle(1'b1);
        checkOutput("stream_empty", 8'(res_valid), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
